traffic_light_monitor: RTL and testbench
========================================

# traffic_light_monitor

Passive checker that sits on the six lamp outputs of the two-way traffic light controller and reads them every clock. It tracks the intersection phase, measures the length of each phase, and checks that the lamp patterns obey the protocol. It raises a sticky fault with a code for the first violation and counts all violations. It drives no lamps; it is instantiated beside the controller in benches and in the top level.

## Interface
Parameters:
- GREEN_MIN, 4, minimum cycles a green phase must last
- YELLOW_MIN, 2, minimum cycles a yellow phase must last
- YELLOW_MAX, 3, maximum cycles a yellow phase may last
- CNT_W, 8, width of the dwell counter

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset (0 = reset)
- A_green, A_yellow, A_red  input  1 each  direction A lamps
- B_green, B_yellow, B_red  input  1 each  direction B lamps
- phase  output  3  monitor state: 0 SYNC, 1 A_GO, 2 A_WARN, 3 ALL_RED, 4 B_GO, 5 B_WARN
- dwell  output  CNT_W  consecutive cycles the current pattern has been sampled, saturating
- fault  output  1  sticky; set on the first violation
- fault_code  output  3  first violation: 0 none, 1 bad encoding, 2 conflict, 3 illegal transition, 4 green short, 5 yellow out of range
- fault_count  output  8  violation cycles, saturates at 255
- cycle_done  output  1  one-cycle pulse on a legal entry into A_GO

## Operation
- Direction encoding is valid only if exactly one of its three lamps is on. Otherwise the cycle raises code 1.
- Valid patterns (A,B) map to states:
  - (G,R) = A_GO
  - (Y,R) = A_WARN
  - (R,R) = ALL_RED
  - (R,G) = B_GO
  - (R,Y) = B_WARN
- Any other pair of valid encodings has both directions non-red and raises code 2.
- Staying in the same pattern is always legal. Legal changes are:
  - A_GO→A_WARN
  - A_WARN→ALL_RED or B_GO
  - B_GO→B_WARN
  - B_WARN→ALL_RED or A_GO
  - ALL_RED→B_GO if the last direction served was A, or A_GO if it was B
- Any other change raises code 3. A 1-bit register holds the last direction served.
- On leaving a green state, the finished dwell must be ≥ GREEN_MIN, else code 4.
- On leaving a yellow state, the finished dwell must be in [YELLOW_MIN, YELLOW_MAX], else code 5.
- A yellow dwell that exceeds YELLOW_MAX raises code 5 immediately, once, at the cycle dwell reaches YELLOW_MAX+1.
- Check priority within one cycle: 1 > 2 > 3 > 4/5. Only the highest-priority violation is latched.
- fault_code latches only when fault is 0.
- fault_count increments by 1 per sampled cycle with any violation.
- SYNC handling:
  - The state after reset is SYNC. The first valid pattern seen enters its state with no transition check.
  - The dwell of that first, partial phase is not duration-checked.
  - From SYNC, ALL_RED resolves the last direction served as B.
- Resync: after code 3, the state becomes the new pattern's state. After code 1 or 2, the state becomes SYNC.
- dwell: set to 1 on a pattern change, incremented on a repeat, saturating at 2^CNT_W−1.

## Timing
- Inputs are sampled at each rising edge. All outputs are registered.
- A violation in the pattern sampled at edge k is visible on fault, fault_code and fault_count immediately after edge k.
- cycle_done is high for exactly the one cycle following the edge that entered A_GO legally (not from SYNC, not via code 3).
- Reset, with reset=0 at an edge:
  - phase=0, dwell=0, fault=0, fault_code=0, fault_count=0, cycle_done=0, last-served=B.
  - A reset asserted mid-phase or while faulted clears everything at that same edge.
  - Lamps are ignored while reset=0.

## Configuration
- TLM_TIMING_CHECK_EN defined: the duration checks (codes 4 and 5) are built in.
- Not defined: codes 4 and 5 are never raised, and that comparison logic is absent. The dwell counter, the transition checks and all ports remain.

## Test plan
- Reset with reset=0 for 2 cycles, then release → phase=0, fault=0, fault_code=0, fault_count=0, dwell=0.
- Legal loop: A green 5, A yellow 2, all-red 1, B green 5, B yellow 3, all-red 1, A green → fault stays 0, phase walks 1,2,3,4,5,3,1, cycle_done pulses once at the final A_GO.
- Conflict: from A_GO, drive A_green=1 and B_green=1 for one cycle → fault=1, fault_code=2, fault_count=1, phase=0 the next cycle.
- Bad encoding: A_green=1 and A_red=1 together → fault_code=1. A later conflict leaves fault_code=1 while fault_count increments.
- Duration (macro defined): A yellow held 5 cycles with YELLOW_MAX=3 → code 5 at the 4th yellow cycle. A green of 3 cycles then yellow → code 4. With the macro undefined, the same stimulus gives fault=0.
- Illegal transition A_GO→B_GO directly → fault_code=3, phase=4. Then reset=0 for one edge → all outputs return to their reset values.

Source files
------------

// File: rtl/traffic_light_monitor.sv
// Passive protocol checker for the six lamps of a two-way traffic light controller.
// Define TLM_TIMING_CHECK_EN to build in the green/yellow duration checks (codes 4 and 5).
module traffic_light_monitor #(
    parameter int unsigned GREEN_MIN  = 4,
    parameter int unsigned YELLOW_MIN = 2,
    parameter int unsigned YELLOW_MAX = 3,
    parameter int unsigned CNT_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             A_green,
    input  logic             A_yellow,
    input  logic             A_red,
    input  logic             B_green,
    input  logic             B_yellow,
    input  logic             B_red,
    output logic [2:0]       phase,
    output logic [CNT_W-1:0] dwell,
    output logic             fault,
    output logic [2:0]       fault_code,
    output logic [7:0]       fault_count,
    output logic             cycle_done
);

    typedef enum logic [2:0] {
        ST_SYNC    = 3'd0,
        ST_A_GO    = 3'd1,
        ST_A_WARN  = 3'd2,
        ST_ALL_RED = 3'd3,
        ST_B_GO    = 3'd4,
        ST_B_WARN  = 3'd5
    } state_e;

    localparam logic [2:0] CODE_NONE     = 3'd0;
    localparam logic [2:0] CODE_ENCODING = 3'd1;
    localparam logic [2:0] CODE_CONFLICT = 3'd2;
    localparam logic [2:0] CODE_TRANS    = 3'd3;
    localparam logic [2:0] CODE_GREEN    = 3'd4;
    localparam logic [2:0] CODE_YELLOW   = 3'd5;

    // Lamp vector order is {A_green, A_yellow, A_red, B_green, B_yellow, B_red}.
    localparam logic [5:0] PAT_GR = 6'b100_001;
    localparam logic [5:0] PAT_YR = 6'b010_001;
    localparam logic [5:0] PAT_RR = 6'b001_001;
    localparam logic [5:0] PAT_RG = 6'b001_100;
    localparam logic [5:0] PAT_RY = 6'b001_010;

    localparam logic [CNT_W-1:0] DWELL_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] DWELL_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] DWELL_SAT  = {CNT_W{1'b1}};

    if ((YELLOW_MIN > YELLOW_MAX) || (GREEN_MIN == 0) || (CNT_W < 2)) begin : g_bad_cfg
        $error("traffic_light_monitor: inconsistent timing parameters");
    end

    function automatic logic one_hot3(input logic [2:0] v);
        return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
    endfunction

    state_e           state_r, state_next_s, pat_state_s;
    logic [CNT_W-1:0] dwell_r, dwell_next_s;
    logic [5:0]       lamps_r, lamps_s;
    logic             fault_r, cycle_done_r, cycle_done_next_s;
    logic [2:0]       code_r, viol_code_s, timing_code_s;
    logic [7:0]       count_r;
    logic             last_b_r, last_b_next_s;
    logic             enc_bad_s, conflict_s, moved_s, trans_ok_s, illegal_s;

    // Decode the sampled lamps into a phase and classify the encoding.
    always_comb begin
        lamps_s   = {A_green, A_yellow, A_red, B_green, B_yellow, B_red};
        enc_bad_s = !(one_hot3(lamps_s[5:3]) && one_hot3(lamps_s[2:0]));
        case (lamps_s)
            PAT_GR:  pat_state_s = ST_A_GO;
            PAT_YR:  pat_state_s = ST_A_WARN;
            PAT_RR:  pat_state_s = ST_ALL_RED;
            PAT_RG:  pat_state_s = ST_B_GO;
            PAT_RY:  pat_state_s = ST_B_WARN;
            default: pat_state_s = ST_SYNC;
        endcase
        conflict_s = !enc_bad_s && (pat_state_s == ST_SYNC);
        moved_s    = (pat_state_s != state_r);
    end

    // Legal successor table; SYNC accepts anything without a check.
    always_comb begin
        trans_ok_s = 1'b0;
        case (state_r)
            ST_A_GO:    trans_ok_s = (pat_state_s == ST_A_WARN);
            ST_A_WARN:  trans_ok_s = (pat_state_s == ST_ALL_RED) || (pat_state_s == ST_B_GO);
            ST_ALL_RED: trans_ok_s = last_b_r ? (pat_state_s == ST_A_GO) : (pat_state_s == ST_B_GO);
            ST_B_GO:    trans_ok_s = (pat_state_s == ST_B_WARN);
            ST_B_WARN:  trans_ok_s = (pat_state_s == ST_ALL_RED) || (pat_state_s == ST_A_GO);
            default:    trans_ok_s = 1'b1;
        endcase
    end

`ifdef TLM_TIMING_CHECK_EN
    logic partial_r;

    function automatic logic is_green(input state_e s);
        return (s == ST_A_GO) || (s == ST_B_GO);
    endfunction

    function automatic logic is_yellow(input state_e s);
        return (s == ST_A_WARN) || (s == ST_B_WARN);
    endfunction

    // Duration checks. Over-long yellow is reported once as dwell crosses YELLOW_MAX,
    // so the exit check of a yellow phase only catches the short case.
    always_comb begin
        timing_code_s = CODE_NONE;
        if ((state_r != ST_SYNC) && !partial_r) begin
            if (moved_s) begin
                if (is_green(state_r) && (dwell_r < CNT_W'(GREEN_MIN))) begin
                    timing_code_s = CODE_GREEN;
                end else if (is_yellow(state_r) && (dwell_r < CNT_W'(YELLOW_MIN))) begin
                    timing_code_s = CODE_YELLOW;
                end else begin
                    timing_code_s = CODE_NONE;
                end
            end else if (is_yellow(state_r) && (dwell_r == CNT_W'(YELLOW_MAX))) begin
                timing_code_s = CODE_YELLOW;
            end else begin
                timing_code_s = CODE_NONE;
            end
        end else begin
            timing_code_s = CODE_NONE;
        end
    end

    // The phase entered out of SYNC was seen only partially, so it is exempt from duration checks.
    always_ff @(posedge clk) begin
        if (!reset) begin
            partial_r <= 1'b0;
        end else if (state_r == ST_SYNC) begin
            partial_r <= 1'b1;
        end else if (moved_s) begin
            partial_r <= 1'b0;
        end
    end
`else
    // Duration checks are not built in this configuration.
    always_comb timing_code_s = CODE_NONE;
`endif

    // Prioritise violations and work out the next phase, last-served direction and dwell.
    always_comb begin
        illegal_s = !enc_bad_s && !conflict_s && (state_r != ST_SYNC) && moved_s && !trans_ok_s;
        if (enc_bad_s) begin
            viol_code_s = CODE_ENCODING;
        end else if (conflict_s) begin
            viol_code_s = CODE_CONFLICT;
        end else if (illegal_s) begin
            viol_code_s = CODE_TRANS;
        end else begin
            viol_code_s = timing_code_s;
        end

        if (enc_bad_s || conflict_s) begin
            state_next_s = ST_SYNC;
        end else begin
            state_next_s = pat_state_s;
        end

        last_b_next_s = last_b_r;
        case (state_next_s)
            ST_A_GO, ST_A_WARN: last_b_next_s = 1'b0;
            ST_B_GO, ST_B_WARN: last_b_next_s = 1'b1;
            ST_ALL_RED:         last_b_next_s = (state_r == ST_SYNC) ? 1'b1 : last_b_r;
            default:            last_b_next_s = last_b_r;
        endcase

        cycle_done_next_s = (state_next_s == ST_A_GO) && moved_s && (state_r != ST_SYNC) && !illegal_s;

        if ((lamps_s != lamps_r) || (dwell_r == DWELL_ZERO)) begin
            dwell_next_s = DWELL_ONE;
        end else if (dwell_r == DWELL_SAT) begin
            dwell_next_s = dwell_r;
        end else begin
            dwell_next_s = dwell_r + DWELL_ONE;
        end
    end

    // State, dwell and fault bookkeeping; the first violation code sticks until reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r      <= ST_SYNC;
            dwell_r      <= DWELL_ZERO;
            lamps_r      <= 6'b000_000;
            fault_r      <= 1'b0;
            code_r       <= CODE_NONE;
            count_r      <= 8'd0;
            cycle_done_r <= 1'b0;
            last_b_r     <= 1'b1;
        end else begin
            state_r      <= state_next_s;
            dwell_r      <= dwell_next_s;
            lamps_r      <= lamps_s;
            cycle_done_r <= cycle_done_next_s;
            last_b_r     <= last_b_next_s;
            if (viol_code_s != CODE_NONE) begin
                fault_r <= 1'b1;
                if (!fault_r) begin
                    code_r <= viol_code_s;
                end
                if (count_r != 8'hFF) begin
                    count_r <= count_r + 8'd1;
                end
            end
        end
    end

    assign phase       = state_r;
    assign dwell       = dwell_r;
    assign fault       = fault_r;
    assign fault_code  = code_r;
    assign fault_count = count_r;
    assign cycle_done  = cycle_done_r;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor: vector table plus duration corner sequences.
module tb_traffic_light_monitor;

    localparam logic [5:0] GR  = 6'b100_001;
    localparam logic [5:0] YR  = 6'b010_001;
    localparam logic [5:0] RR  = 6'b001_001;
    localparam logic [5:0] RG  = 6'b001_100;
    localparam logic [5:0] RY  = 6'b001_010;
    localparam logic [5:0] GG  = 6'b100_100;
    localparam logic [5:0] BAD = 6'b101_001;

`ifdef TLM_TIMING_CHECK_EN
    localparam bit TIMING = 1'b1;
`else
    localparam bit TIMING = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic       A_green, A_yellow, A_red, B_green, B_yellow, B_red;
    logic [2:0] phase;
    logic [7:0] dwell;
    logic       fault;
    logic [2:0] fault_code;
    logic [7:0] fault_count;
    logic       cycle_done;

    int n_cmp  = 0;
    int n_fail = 0;

    traffic_light_monitor dut (
        .clk        (clk),
        .reset      (reset),
        .A_green    (A_green),
        .A_yellow   (A_yellow),
        .A_red      (A_red),
        .B_green    (B_green),
        .B_yellow   (B_yellow),
        .B_red      (B_red),
        .phase      (phase),
        .dwell      (dwell),
        .fault      (fault),
        .fault_code (fault_code),
        .fault_count(fault_count),
        .cycle_done (cycle_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic [5:0] lamps;
        logic [2:0] phase;
        logic [7:0] dwell;
        logic       fault;
        logic [2:0] code;
        logic [7:0] count;
        logic       cd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic [5:0] l, input logic [2:0] p,
                                input logic [7:0] d, input logic f, input logic [2:0] c,
                                input logic [7:0] n, input logic cd);
        vec_t v;
        v.rst_n = r; v.lamps = l; v.phase = p; v.dwell = d;
        v.fault = f; v.code = c; v.count = n; v.cd = cd;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0d, expected %0d", name, idx, act, exp);
        end
    endtask

    // Drive one sample, clock it, and settle just after the edge.
    task automatic apply(input logic r, input logic [5:0] l);
        reset = r;
        {A_green, A_yellow, A_red, B_green, B_yellow, B_red} = l;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        {A_green, A_yellow, A_red, B_green, B_yellow, B_red} = 6'b000_000;

        // reset, legal loop
        vecs.push_back(mk(0, GR, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, GR, 0, 0, 0, 0, 0, 0));
        for (int i = 1; i <= 5; i++) vecs.push_back(mk(1, GR, 1, 8'(i), 0, 0, 0, 0));
        vecs.push_back(mk(1, YR, 2, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, YR, 2, 2, 0, 0, 0, 0));
        vecs.push_back(mk(1, RR, 3, 1, 0, 0, 0, 0));
        for (int i = 1; i <= 5; i++) vecs.push_back(mk(1, RG, 4, 8'(i), 0, 0, 0, 0));
        for (int i = 1; i <= 3; i++) vecs.push_back(mk(1, RY, 5, 8'(i), 0, 0, 0, 0));
        vecs.push_back(mk(1, RR, 3, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, GR, 1, 1, 0, 0, 0, 1));
        vecs.push_back(mk(1, GR, 1, 2, 0, 0, 0, 0));
        // conflict, then resync from SYNC with no pulse
        vecs.push_back(mk(1, GG, 0, 1, 1, 2, 1, 0));
        vecs.push_back(mk(1, GR, 1, 1, 1, 2, 1, 0));
        // bad encoding keeps code 1 while count keeps growing
        vecs.push_back(mk(0, GR, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, BAD, 0, 1, 1, 1, 1, 0));
        vecs.push_back(mk(1, GG, 0, 1, 1, 1, 2, 0));
        vecs.push_back(mk(1, GG, 0, 2, 1, 1, 3, 0));
        // illegal A_GO -> B_GO, then a single reset edge
        vecs.push_back(mk(0, GR, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, GR, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, GR, 1, 2, 0, 0, 0, 0));
        vecs.push_back(mk(1, RG, 4, 1, 1, 3, 1, 0));
        vecs.push_back(mk(0, RG, 0, 0, 0, 0, 0, 0));

        foreach (vecs[i]) begin
            apply(vecs[i].rst_n, vecs[i].lamps);
            chk("phase", i, 8'(phase), 8'(vecs[i].phase));
            chk("dwell", i, dwell, vecs[i].dwell);
            chk("fault", i, 8'(fault), 8'(vecs[i].fault));
            chk("fault_code", i, 8'(fault_code), 8'(vecs[i].code));
            chk("fault_count", i, fault_count, vecs[i].count);
            chk("cycle_done", i, 8'(cycle_done), 8'(vecs[i].cd));
        end

        // Long yellow: green of exactly GREEN_MIN is fine, overflow flagged on the 4th yellow.
        apply(0, RR);
        apply(1, RR);
        apply(1, GR);
        chk("seqA_cd_from_allred", 100, 8'(cycle_done), 8'd1);
        for (int i = 0; i < 3; i++) apply(1, GR);
        chk("seqA_green_dwell", 101, dwell, 8'd4);
        apply(1, YR);
        chk("seqA_green_min_ok", 102, 8'(fault), 8'd0);
        apply(1, YR);
        apply(1, YR);
        chk("seqA_yellow3_ok", 103, 8'(fault), 8'd0);
        apply(1, YR);
        chk("seqA_yellow_over_code", 104, 8'(fault_code), TIMING ? 8'd5 : 8'd0);
        chk("seqA_yellow_over_fault", 105, 8'(fault), TIMING ? 8'd1 : 8'd0);
        apply(1, YR);
        chk("seqA_yellow_over_once", 106, fault_count, TIMING ? 8'd1 : 8'd0);
        chk("seqA_dwell5", 107, dwell, 8'd5);

        // Short green: 3 cycles then yellow.
        apply(0, RR);
        apply(1, RR);
        for (int i = 0; i < 3; i++) apply(1, GR);
        apply(1, YR);
        chk("seqB_green_short_code", 200, 8'(fault_code), TIMING ? 8'd4 : 8'd0);
        chk("seqB_green_short_phase", 201, 8'(phase), 8'd2);

        // Short yellow: 1 cycle then all-red.
        apply(0, RR);
        apply(1, RR);
        for (int i = 0; i < 4; i++) apply(1, GR);
        apply(1, YR);
        apply(1, RR);
        chk("seqC_yellow_short_code", 300, 8'(fault_code), TIMING ? 8'd5 : 8'd0);
        chk("seqC_yellow_short_count", 301, fault_count, TIMING ? 8'd1 : 8'd0);
        chk("seqC_phase", 302, 8'(phase), 8'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
